scan_ctrl: RTL and testbench
============================

Name: scan_ctrl

Overview:
Scan-chain controller that sits directly upstream and downstream of a scan-inserted design.
- Drives the design's scan_en and scan_in, and consumes its scan_out.
- On command, rotates the whole chain once. It either captures the state non-destructively (loop-back) or loads new state while unloading the old.
- The captured chain contents go to a host-side register with a valid pulse.
- Used by on-chip debug to snapshot and restore designs such as the 8-bit counter.

Parameters:
CHAIN_LEN, 8, number of flops in the attached scan chain (>=1).
CNT_W, $clog2(CHAIN_LEN+1), shift-counter width (derived, not overridden).

Ports:
clk  in  1  design clock, rising edge.
rst  in  1  asynchronous reset, active-low (asserted when 0).
cmd_valid  in  1  command request.
cmd_ready  out  1  high when a command can be accepted.
cmd_op  in  2  0=CAPTURE, 1=LOAD, 2=SWAP, 3=reserved (treated as CAPTURE).
load_data  in  CHAIN_LEN  state to shift in for LOAD/SWAP, sampled at accept.
chain_en  out  1  to the design's scan_en.
chain_si  out  1  to the design's scan_in.
chain_so  in  1  from the design's scan_out.
dump_data  out  CHAIN_LEN  bits unloaded by the last operation.
dump_valid  out  1  one-cycle pulse when dump_data is updated.
busy  out  1  high while an operation is in progress.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; chain_en=0, dump_data=0, dump_valid=0, busy=0, counter=0.
  - cmd_ready=1 once rst releases.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready=1.
  - On a clk edge with cmd_valid&cmd_ready: latch op, latch load_data into load_sr, clear counter, go to SHIFT.
  - chain_en is registered and goes high in the same edge.
- SHIFT:
  - chain_en=1, busy=1, cmd_ready=0.
  - Each edge:
    - sample chain_so into dump_sr[counter], so the first bit out lands in dump_data[0];
    - right-shift load_sr;
    - increment counter.
  - After exactly CHAIN_LEN shift edges, chain_en drops to 0 in the same edge and the block goes to DONE.
  - chain_en is never high for more or fewer than CHAIN_LEN cycles.
- chain_si (combinational):
  - CAPTURE: chain_si = chain_so (loop-back). After CHAIN_LEN shifts the design state is bit-identical to its pre-shift state.
  - LOAD/SWAP: chain_si = load_sr[0], i.e. load_data is shifted LSB-first. The design ends holding load_data bit i in the chain position from which dump bit i was unloaded.
  - IDLE/DONE: chain_si = 0.
- LOAD vs SWAP: identical on the chain side.
  - SWAP updates dump_data.
  - LOAD leaves dump_data unchanged and produces no dump_valid.
- DONE:
  - One cycle; busy=1.
  - For CAPTURE/SWAP: dump_data <= dump_sr and dump_valid=1 for this cycle only.
  - Then go to IDLE.
- Latency: accept edge t → chain_en high during cycles t+1..t+CHAIN_LEN → dump_valid at cycle t+CHAIN_LEN+1 → cmd_ready again at t+CHAIN_LEN+2.
- Snapshot point: the design's functional state at the accept edge. While chain_en=1 the design does not run functionally.
- Back-to-back: a command presented while busy is held off (cmd_ready=0) and accepted on the first IDLE cycle.
- Reset mid-SHIFT:
  - chain_en drops immediately (async).
  - The chain is left partially rotated. This is documented and not recovered.
  - dump_data is cleared; no dump_valid.
- Counter never wraps; the terminal compare is against CHAIN_LEN-1 at the sampling edge.

Decomposition:
- Shared package scan_pkg:
  - op encodings SCAN_OP_CAPTURE/LOAD/SWAP;
  - state enum;
  - the CNT_W derivation function.
- One natural sub-module, scan_shift_reg: a CHAIN_LEN-wide shift register with serial-in/serial-out, load and clear. It is instantiated twice, for load_sr and dump_sr.

Test Plan:
1. Reset, then run the counter to result=0x2A; issue CAPTURE → chain_en high exactly 8 cycles; dump_valid once with dump_data = chain image of 0x2A; counter resumes at 0x2B afterwards.
2. LOAD with load_data=0x80 → after completion the counter result reads the value mapped from 0x80 and then increments; dump_valid never pulses; dump_data keeps its prior value.
3. SWAP with load_data=0x00 while the counter holds 0x55 → dump_data = image of 0x55; counter restarts from 0.
4. Hold cmd_valid high with op=CAPTURE continuously → commands accepted every CHAIN_LEN+2 = 10 cycles; chain_en never exceeds 8 consecutive cycles.
5. Assert rst=0 on the 4th shift cycle → chain_en, busy and dump_data go to 0 asynchronously with no clock edge; no dump_valid; cmd_ready=1 after release.
6. Param CHAIN_LEN=1 with a single-flop chain → chain_en high exactly 1 cycle; dump_data[0] equals the flop value; CAPTURE leaves the flop unchanged.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain controller: op codes, FSM states, counter sizing.
// Latency: n/a (package).
// Backpressure: n/a (package).
package scan_pkg;

    localparam logic [1:0] SCAN_OP_CAPTURE = 2'd0;
    localparam logic [1:0] SCAN_OP_LOAD    = 2'd1;
    localparam logic [1:0] SCAN_OP_SWAP    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_e;

    // Shift counter must hold 0..chain_len without wrapping.
    function automatic int scan_cnt_w(input int chain_len);
        return (chain_len < 1) ? 1 : $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Right-shifting register with serial input at the MSB, parallel load and clear.
// Latency: one cycle per operation; clear beats load beats shift.
// Backpressure: none, the owner decides when to shift.
module scan_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_dat_i,
    input  logic         shift_i,
    input  logic         si_i,
    output logic [W-1:0] dat_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;
    logic [W-1:0] shifted;

    // Next value: bit 0 falls out, serial input enters at the top.
    always_comb begin
        shifted        = sr_q >> 1;
        shifted[W-1]   = si_i;
        sr_d           = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (load_i) begin
            sr_d = load_dat_i;
        end else if (shift_i) begin
            sr_d = shifted;
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dat_o = sr_q;

endmodule

// File: rtl/scan_ctrl.sv
// Scan-chain controller: rotates an attached chain once per command (capture, load or swap).
// Latency: accept at t, chain_en for CHAIN_LEN cycles, dump_valid at t+CHAIN_LEN+1, ready at t+CHAIN_LEN+2.
// Backpressure: cmd_ready is low from accept until back in IDLE; held commands wait there.
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = scan_cnt_w(CHAIN_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CHAIN_LEN-1:0] load_data,
    output logic                 chain_en,
    output logic                 chain_si,
    input  logic                 chain_so,
    output logic [CHAIN_LEN-1:0] dump_data,
    output logic                 dump_valid,
    output logic                 busy
);

    scan_state_e          state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 chain_en_q, chain_en_d;
    logic [CHAIN_LEN-1:0] dump_data_q, dump_data_d;
    logic [CHAIN_LEN-1:0] load_sr;
    logic [CHAIN_LEN-1:0] dump_sr;
    logic                 accept;
    logic                 shifting;
    logic                 last_shift;
    logic                 op_dumps;
    logic                 op_loads;
    logic                 load_sr_unused;

    assign accept     = cmd_valid && cmd_ready;
    assign shifting   = (state_q == ST_SHIFT);
    assign last_shift = shifting && (cnt_q == CNT_W'(CHAIN_LEN - 1));
    // Reserved op 3 behaves as CAPTURE, so everything except LOAD reports a dump.
    assign op_dumps   = (op_q != SCAN_OP_LOAD);
    assign op_loads   = (op_q == SCAN_OP_LOAD) || (op_q == SCAN_OP_SWAP);

    // Only bit 0 of the load register feeds the chain; the rest is shift storage.
    assign load_sr_unused = ^load_sr;

    // Outgoing data, shifted LSB-first into the chain.
    scan_shift_reg #(.W(CHAIN_LEN)) u_load_sr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .load_i     (accept),
        .load_dat_i (load_data),
        .shift_i    (shifting),
        .si_i       (1'b0),
        .dat_o      (load_sr)
    );

    // Unloaded chain bits enter at the top; after CHAIN_LEN shifts the first bit out sits in bit 0.
    scan_shift_reg #(.W(CHAIN_LEN)) u_dump_sr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .load_i     (1'b0),
        .load_dat_i ('0),
        .shift_i    (shifting),
        .si_i       (chain_so),
        .dat_o      (dump_sr)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one rotation of CHAIN_LEN edges, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; during DONE the finished dump is shown directly so data and valid coincide.
    always_comb begin
        cmd_ready  = rst && (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        dump_valid = (state_q == ST_DONE) && op_dumps;
        dump_data  = dump_valid ? dump_sr : dump_data_q;
        chain_en   = chain_en_q;
        chain_si   = 1'b0;
        if (shifting) begin
            chain_si = op_loads ? load_sr[0] : chain_so;
        end
    end

    // Datapath next values: op latch, shift counter, registered scan enable, held dump.
    always_comb begin
        op_d        = accept ? cmd_op : op_q;
        cnt_d       = cnt_q;
        chain_en_d  = chain_en_q;
        dump_data_d = dump_data_q;
        if (accept) begin
            cnt_d      = '0;
            chain_en_d = 1'b1;
        end else if (shifting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_shift) begin
            chain_en_d = 1'b0;
        end
        if (dump_valid) begin
            dump_data_d = dump_sr;
        end
    end

    // Datapath registers; an async reset drops chain_en at once and abandons the rotation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= SCAN_OP_CAPTURE;
            cnt_q       <= '0;
            chain_en_q  <= 1'b0;
            dump_data_q <= '0;
        end else begin
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            chain_en_q  <= chain_en_d;
            dump_data_q <= dump_data_d;
        end
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl driving a scan-inserted 8-bit counter and a single-flop chain.
// Latency: checks dump timing against the accept edge.
// Backpressure: commands wait on cmd_ready with a bounded loop.
module tb_scan_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 8-flop instance
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [N-1:0] load_data = '0;
    logic         chain_en, chain_si, chain_so;
    logic [N-1:0] dump_data;
    logic         dump_valid, busy;

    // 1-flop instance
    logic       cmd_valid1 = 1'b0;
    logic       cmd_ready1;
    logic [1:0] cmd_op1 = 2'd0;
    logic [0:0] load_data1 = '0;
    logic       chain_en1, chain_si1, chain_so1;
    logic [0:0] dump_data1;
    logic       dump_valid1, busy1;

    scan_ctrl #(.CHAIN_LEN(N)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .load_data(load_data), .chain_en(chain_en),
        .chain_si(chain_si), .chain_so(chain_so), .dump_data(dump_data),
        .dump_valid(dump_valid), .busy(busy)
    );

    scan_ctrl #(.CHAIN_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op1), .load_data(load_data1), .chain_en(chain_en1),
        .chain_si(chain_si1), .chain_so(chain_so1), .dump_data(dump_data1),
        .dump_valid(dump_valid1), .busy(busy1)
    );

    // Scan-inserted 8-bit counter: scan has priority, chain runs scan_in -> bit7 ... bit0 -> scan_out.
    logic [N-1:0] q;
    logic         cnt_en = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst)          q <= '0;
        else if (chain_en) q <= {chain_si, q[N-1:1]};
        else if (cnt_en)   q <= q + 8'd1;
    end
    assign chain_so = q[0];

    // Single scan flop with a toggle function.
    logic f1;
    logic tog1 = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst)           f1 <= 1'b0;
        else if (chain_en1) f1 <= chain_si1;
        else if (tog1)      f1 <= ~f1;
    end
    assign chain_so1 = f1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: the design's logical state and the host-visible dump.
    typedef struct {
        logic [N-1:0] d;
        int           acc;
    } exp_t;
    exp_t         sbq[$];
    logic [N-1:0] gold      = '0;
    logic [N-1:0] last_dump = '0;

    // Monitor: scan-enable run length and every dump pulse against the scoreboard.
    int run = 0;
    always @(negedge clk) begin
        if (!rst) begin
            run = 0;
        end else begin
            if (chain_en) begin
                run++;
            end else if (run != 0) begin
                chk("chain_en_run", run, N);
                run = 0;
            end
            if (dump_valid) begin
                if (sbq.size() == 0) begin
                    chk("dump_valid_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("dump_data", dump_data, e.d);
                    chk("dump_latency", cyc, e.acc + N);
                end
            end
        end
    end

    // Present a command at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] d, output int acc);
        int w;
        cmd_valid = 1'b1;
        cmd_op    = op;
        load_data = d;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (op != 2'd1) begin
            sbq.push_back('{d: gold, acc: acc});
            last_dump = gold;
        end
        if (op == 2'd1 || op == 2'd2) gold = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic count(input int n);
        cnt_en = 1'b1;
        repeat (n) @(negedge clk);
        cnt_en = 1'b0;
        gold = gold + N'(n);
    endtask

    initial begin
        int a0, a1, a2;
        logic [1:0] op;
        logic [N-1:0] d;
        logic exp_f;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_chain_en", chain_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_data", dump_data, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);

        // Capture 0x2A, counter resumes at 0x2B
        count(42);
        issue(2'd0, '0, a0);
        cmd_valid = 1'b0;
        wait_idle();
        chk("cap_state", q, gold);
        count(1);
        chk("cap_resume", q, 8'h2B);

        // LOAD 0x80: no dump, dump_data held, then increments
        issue(2'd1, 8'h80, a0);
        cmd_valid = 1'b0;
        wait_idle();
        chk("load_state", q, 8'h80);
        chk("load_dump_held", dump_data, last_dump);
        count(1);
        chk("load_resume", q, 8'h81);

        // SWAP 0x00 while holding 0x55
        issue(2'd1, 8'h55, a0);
        cmd_valid = 1'b0;
        wait_idle();
        issue(2'd2, 8'h00, a0);
        cmd_valid = 1'b0;
        wait_idle();
        chk("swap_state", q, 8'h00);
        count(3);
        chk("swap_restart", q, 8'h03);

        // Held cmd_valid: accepts every N+2 cycles
        issue(2'd0, '0, a0);
        issue(2'd0, '0, a1);
        issue(2'd0, '0, a2);
        cmd_valid = 1'b0;
        chk("b2b_gap1", a1 - a0, N + 2);
        chk("b2b_gap2", a2 - a1, N + 2);
        wait_idle();
        chk("b2b_state", q, gold);

        // Reset on the 4th shift cycle
        issue(2'd0, '0, a0);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_chain_en", chain_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dump_data", dump_data, 0);
        chk("midrst_dump_valid", dump_valid, 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        gold = '0;
        last_dump = '0;
        @(negedge clk);
        chk("midrst_cmd_ready", cmd_ready, 1);

        // Randomized commands against the reference
        for (int i = 0; i < 40; i++) begin
            count($urandom_range(0, 6));
            op = 2'($urandom_range(0, 3));
            d  = N'($urandom);
            issue(op, d, a0);
            cmd_valid = 1'b0;
            wait_idle();
            chk("rand_state", q, gold);
        end
        chk("final_dump_data", dump_data, last_dump);

        // Single-flop chain: CAPTURE keeps the flop, SWAP with 0 clears it
        tog1 = 1'b1;
        @(negedge clk);
        tog1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_f      = (k == 0) ? 1'b1 : 1'b0;
            cmd_valid1 = 1'b1;
            cmd_op1    = (k == 0) ? 2'd0 : 2'd2;
            load_data1 = '0;
            chk("n1_ready", cmd_ready1, 1);
            @(negedge clk);
            cmd_valid1 = 1'b0;
            chk("n1_chain_en_on", chain_en1, 1);
            @(negedge clk);
            chk("n1_chain_en_off", chain_en1, 0);
            chk("n1_dump_valid", dump_valid1, 1);
            chk("n1_dump_data", dump_data1, 1);
            @(negedge clk);
            chk("n1_dump_valid_drop", dump_valid1, 0);
            chk("n1_ready_again", cmd_ready1, 1);
            chk("n1_flop", f1, exp_f);
        end

        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
